// File: rtl/ex_issue_stage.sv
// rtl/ex_issue_stage.sv - execute-stage front end: ID/EX and EX/MEM registers, flags, branch redirect
module ex_issue_stage #(
  parameter int WIDTH = 16,
  parameter int RD_W  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [RD_W-1:0]  in_rd,
  input  logic [1:0]       in_br,
  input  logic [WIDTH-1:0] in_target,
  output logic [2:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_z,
  input  logic             alu_v,
  input  logic             alu_n,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [RD_W-1:0]  out_rd,
  output logic             flag_z,
  output logic             flag_v,
  output logic             flag_n,
  output logic             redirect_valid,
  output logic [WIDTH-1:0] redirect_pc
);

  logic             s1_valid;
  logic [2:0]       s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [RD_W-1:0]  s1_rd;
  logic [1:0]       s1_br;
  logic [WIDTH-1:0] s1_target;

  logic s1_is_br;
  logic s1_adv;
  logic accept;
  logic br_cond;
  logic br_taken;
  logic s2_load;

  assign alu_op = s1_valid ? s1_op : 3'b000;
  assign alu_a  = s1_valid ? s1_a  : '0;
  assign alu_b  = s1_valid ? s1_b  : '0;

  // Branches never occupy S2, so they advance regardless of downstream backpressure.
  assign s1_is_br = (s1_br != 2'b00);
  assign s1_adv   = s1_valid && (s1_is_br || !out_valid || out_ready);
  assign in_ready = !rst && (!s1_valid || s1_adv);
  assign accept   = in_valid && in_ready;
  assign s2_load  = s1_adv && !s1_is_br;

  // Condition comes from the branch's own ALU evaluation, not the architectural flags.
  always_comb begin
    br_cond = 1'b0;
    case (s1_br)
      2'b01:   br_cond = alu_z;
      2'b10:   br_cond = !alu_z;
      2'b11:   br_cond = alu_n;
      default: br_cond = 1'b0;
    endcase
  end

  assign br_taken = s1_adv && s1_is_br && br_cond;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid       <= 1'b0;
      s1_op          <= '0;
      s1_a           <= '0;
      s1_b           <= '0;
      s1_rd          <= '0;
      s1_br          <= '0;
      s1_target      <= '0;
      out_valid      <= 1'b0;
      out_result     <= '0;
      out_rd         <= '0;
      flag_z         <= 1'b0;
      flag_v         <= 1'b0;
      flag_n         <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      redirect_valid <= br_taken;
      if (br_taken) begin
        redirect_pc <= s1_target;
      end

      // The op accepted alongside a taken branch is wrong-path: handshake completes, entry is dropped.
      if (accept) begin
        s1_valid  <= !br_taken;
        s1_op     <= in_op;
        s1_a      <= in_a;
        s1_b      <= in_b;
        s1_rd     <= in_rd;
        s1_br     <= in_br;
        s1_target <= in_target;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end

      if (s2_load) begin
        out_valid  <= 1'b1;
        out_result <= alu_result;
        out_rd     <= s1_rd;
        flag_z     <= alu_z;
        flag_v     <= alu_v;
        flag_n     <= alu_n;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ex_issue_stage.sv
// tb/tb_ex_issue_stage.sv - directed and randomized bench for ex_issue_stage with a transaction-level model
module tb_ex_issue_stage;

  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, NAND = 3'd2, XOR = 3'd3;
  localparam logic [2:0] INC = 3'd4, SRA = 3'd5, SRL = 3'd6, SLL = 3'd7;

  logic        clk, rst;
  logic        in_valid, in_ready;
  logic [2:0]  in_op;
  logic [15:0] in_a, in_b, in_target;
  logic [2:0]  in_rd;
  logic [1:0]  in_br;
  logic [2:0]  alu_op;
  logic [15:0] alu_a, alu_b, alu_result;
  logic        alu_z, alu_v, alu_n;
  logic        out_valid, out_ready;
  logic [15:0] out_result;
  logic [2:0]  out_rd;
  logic        flag_z, flag_v, flag_n;
  logic        redirect_valid;
  logic [15:0] redirect_pc;

  ex_issue_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .in_rd(in_rd), .in_br(in_br), .in_target(in_target),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .alu_z(alu_z), .alu_v(alu_v), .alu_n(alu_n),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_rd(out_rd),
    .flag_z(flag_z), .flag_v(flag_v), .flag_n(flag_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  // Returns {z, v, n, result} for one ALU operation.
  function automatic logic [18:0] alu_f(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    logic        v;
    v = 1'b0;
    case (op)
      ADD:  begin r = a + b;     v = (a[15] == b[15]) && (r[15] != a[15]); end
      SUB:  begin r = a - b;     v = (a[15] != b[15]) && (r[15] != a[15]); end
      NAND: r = ~(a & b);
      XOR:  r = a ^ b;
      INC:  begin r = a + 16'd1; v = (a == 16'h7FFF); end
      SRA:  r = 16'($signed(a) >>> b[3:0]);
      SRL:  r = a >> b[3:0];
      default: r = a << b[3:0];
    endcase
    return {(r == 16'h0), v, r[15], r};
  endfunction

  always_comb {alu_z, alu_v, alu_n, alu_result} = alu_f(alu_op, alu_a, alu_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] res;
    logic [2:0]  rd;
    logic [2:0]  f;
  } ent_t;

  ent_t        q[$];
  logic [2:0]  last_f;
  logic        s1_tk;
  logic [15:0] s1_tgt;
  int          total, bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one cycle from a negedge, advances the model across the posedge, checks at the next negedge.
  task automatic step(input logic v, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic [2:0] rd, input logic [1:0] br, input logic [15:0] tgt, input logic ordy);
    logic        acc, stall, exp_rv;
    logic [15:0] held, exp_pc;
    logic [18:0] f;
    logic [2:0]  exp_f;
    ent_t        e;
    in_valid = v; in_op = op; in_a = a; in_b = b; in_rd = rd; in_br = br; in_target = tgt;
    out_ready = ordy;
    #1;
    acc   = v && in_ready;
    stall = out_valid && !ordy;
    held  = out_result;
    if (out_valid && ordy) begin
      chk("drain_has_entry", 32'(q.size() > 0), 1);
      if (q.size() > 0) begin
        chk("out_result", out_result, q[0].res);
        chk("out_rd", out_rd, q[0].rd);
        last_f = q[0].f;
        void'(q.pop_front());
      end
    end
    exp_rv = s1_tk;
    exp_pc = s1_tgt;
    if (acc && !s1_tk) begin
      f = alu_f(op, a, b);
      if (br != 2'b00) begin
        s1_tk  = (br == 2'b01 && f[18]) || (br == 2'b10 && !f[18]) || (br == 2'b11 && f[16]);
        s1_tgt = tgt;
      end else begin
        s1_tk = 1'b0;
        e.res = f[15:0]; e.rd = rd; e.f = f[18:16];
        q.push_back(e);
      end
    end else begin
      s1_tk = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    chk("redirect_valid", redirect_valid, exp_rv);
    if (exp_rv) chk("redirect_pc", redirect_pc, exp_pc);
    if (stall) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_result", out_result, held);
    end
    exp_f = (out_valid && q.size() > 0) ? q[0].f : last_f;
    chk("flags", {flag_z, flag_v, flag_n}, exp_f);
    chk("spurious_out", 32'(out_valid && q.size() == 0), 0);
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, ADD, 16'h0, 16'h0, 3'd0, 2'b00, 16'h0, ordy);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_redirect", redirect_valid, 0);
    chk("rst_flags", {flag_z, flag_v, flag_n}, 0);
    chk("rst_result", out_result, 0);
    chk("rst_rd", out_rd, 0);
    chk("rst_pc", redirect_pc, 0);
    rst = 1'b0;
    q.delete(); last_f = 3'b000; s1_tk = 1'b0; s1_tgt = 16'h0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; in_valid = 1'b0; in_op = 3'd0; in_a = 16'h0; in_b = 16'h0;
    in_rd = 3'd0; in_br = 2'b00; in_target = 16'h0; out_ready = 1'b0;
    last_f = 3'b000; s1_tk = 1'b0; s1_tgt = 16'h0;
    @(negedge clk);
    do_reset();

    // Basic ADD with two-edge latency.
    step(1'b1, ADD, 16'h0003, 16'h0004, 3'd2, 2'b00, 16'h0, 1'b1);
    chk("lat_not_yet", out_valid, 0);
    idle(1'b1);
    chk("add_valid", out_valid, 1);
    chk("add_result", out_result, 16'h0007);
    chk("add_rd", out_rd, 3'd2);
    chk("add_flags", {flag_z, flag_v, flag_n}, 3'b000);

    // Back-to-back overflow then zero.
    step(1'b1, ADD, 16'h7FFF, 16'h0001, 3'd1, 2'b00, 16'h0, 1'b1);
    step(1'b1, SUB, 16'h0005, 16'h0005, 3'd3, 2'b00, 16'h0, 1'b1);
    chk("ovf_result", out_result, 16'h8000);
    chk("ovf_flags", {flag_z, flag_v, flag_n}, 3'b011);
    idle(1'b1);
    chk("zero_result", out_result, 16'h0000);
    chk("zero_flags", {flag_z, flag_v, flag_n}, 3'b100);
    idle(1'b1);

    // Backpressure with S1 and S2 full.
    step(1'b1, ADD, 16'h0001, 16'h0001, 3'd4, 2'b00, 16'h0, 1'b0);
    step(1'b1, ADD, 16'h0002, 16'h0002, 3'd5, 2'b00, 16'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, XOR, 16'h1234, 16'h4321, 3'd6, 2'b00, 16'h0, 1'b0);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_hold", out_result, 16'h0002);
    end
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Taken branch squashes the op offered as it advances; flags untouched.
    step(1'b1, SUB, 16'h0009, 16'h0009, 3'd0, 2'b01, 16'h0040, 1'b1);
    step(1'b1, XOR, 16'hAAAA, 16'h5555, 3'd7, 2'b00, 16'h0, 1'b1);
    chk("br_redirect", redirect_valid, 1);
    chk("br_pc", redirect_pc, 16'h0040);
    chk("br_flag_z", flag_z, 0);
    idle(1'b1);
    chk("br_pulse_end", redirect_valid, 0);
    chk("br_no_xor", out_valid, 0);

    // Not-taken branch then a normal op; then br=11 on a negative result.
    step(1'b1, SUB, 16'h0009, 16'h0008, 3'd0, 2'b01, 16'h0050, 1'b1);
    step(1'b1, ADD, 16'h0001, 16'h0002, 3'd6, 2'b00, 16'h0, 1'b1);
    chk("nt_no_redirect", redirect_valid, 0);
    idle(1'b1);
    chk("nt_result", out_result, 16'h0003);
    step(1'b1, SUB, 16'h0003, 16'h0005, 3'd0, 2'b11, 16'h0060, 1'b1);
    idle(1'b1);
    chk("n_redirect", redirect_valid, 1);
    chk("n_pc", redirect_pc, 16'h0060);
    idle(1'b1);

    // Reset with S2 valid and a redirect pending.
    step(1'b1, INC, 16'h7FFF, 16'h0, 3'd1, 2'b00, 16'h0, 1'b0);
    step(1'b1, SUB, 16'h0009, 16'h0009, 3'd0, 2'b01, 16'h0070, 1'b0);
    idle(1'b0);
    chk("pre_rst_redirect", redirect_valid, 1);
    chk("pre_rst_out_valid", out_valid, 1);
    do_reset();

    // Reset with S1 and S2 both full.
    step(1'b1, NAND, 16'hFFFF, 16'h00FF, 3'd2, 2'b00, 16'h0, 1'b0);
    step(1'b1, SLL, 16'h0001, 16'h0004, 3'd3, 2'b00, 16'h0, 1'b0);
    chk("pre_rst_full", in_ready, 0);
    do_reset();

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      logic [15:0] ra, rb;
      logic [1:0]  rbr;
      ra  = 16'($urandom);
      rb  = ($urandom_range(0, 3) == 0) ? ra : 16'($urandom);
      rbr = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      step(1'($urandom_range(0, 3) != 0), 3'($urandom), ra, rb, 3'($urandom), rbr,
           16'($urandom), 1'($urandom_range(0, 2) != 0));
    end

    for (int i = 0; i < 20 && q.size() > 0; i++) idle(1'b1);
    chk("final_queue_empty", 32'(q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
